sram_axi_initiator: RTL and testbench
=====================================

SRAM_AXI_INITIATOR -- requirements
Module: sram_axi_initiator

Interface
REQ-001 AXI_ID, 4'd0: value driven on arid and awid.
REQ-002 clk  input  1  sole clock; all flops on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 cpu_req  input  1  CPU transaction request.
REQ-005 cpu_wr  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  input  32  byte address.
REQ-007 cpu_wdata / cpu_wstrb  input  64 / 8  write data and byte enables.
REQ-008 cpu_addr_ok  output  1  request accepted this cycle.
REQ-009 cpu_data_ok  output  1  one-cycle completion pulse.
REQ-010 cpu_rdata / cpu_err  output  64 / 1  read data; error flag for the completed transaction.
REQ-011 arid/araddr/arlen/arsize/arburst  output  4/32/8/3/2  AR payload.
REQ-012 arvalid  output  1, arready  input  1  AR handshake.
REQ-013 rdata/rresp/rlast  input  64/2/1, rvalid  input  1, rready  output  1  R channel.
REQ-014 awid/awaddr/awlen/awsize/awburst  output  4/32/8/3/2  AW payload.
REQ-015 awvalid  output  1, awready  input  1  AW handshake.
REQ-016 wdata/wstrb/wlast  output  64/8/1, wvalid  output  1, wready  input  1  W channel.
REQ-017 bresp  input  2, bvalid  input  1, bready  output  1  B channel.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_REQ and WR_RESP, with at most one transaction outstanding.
REQ-019 cpu_addr_ok SHALL equal cpu_req AND (state == IDLE) (combinational); on acceptance cpu_wr, cpu_addr, cpu_wdata and cpu_wstrb are latched.
REQ-020 Accepted read: IDLE -> RD_ADDR with arvalid=1 from the next cycle; araddr SHALL stay stable until arvalid&&arready, then -> RD_DATA.
REQ-021 In RD_DATA, rready SHALL be 1; on rvalid&&rready, rdata is captured into cpu_rdata, cpu_err=(rresp!=2'b00), state -> IDLE; rlast is ignored.
REQ-022 Accepted write: IDLE -> WR_REQ with awvalid=1 and wvalid=1 from the next cycle.
REQ-023 In WR_REQ, awvalid and wvalid SHALL each drop independently in the cycle after their own handshake.
REQ-024 WR_REQ -> WR_RESP once both the AW and W handshakes have occurred, including when both occur in the same cycle.
REQ-025 In WR_RESP, bready SHALL be 1; on bvalid, cpu_err=bresp[1] and state -> IDLE.
REQ-026 cpu_data_ok SHALL be a registered pulse of exactly one cycle, in the cycle after the R or B handshake.
REQ-027 cpu_rdata SHALL hold its value until the next read completes.
REQ-028 A valid SHALL never deassert before its handshake, and its payload SHALL not change while valid is high.
REQ-029 Constants: arlen=awlen=0, arsize=awsize=3'b011, arburst=awburst=2'b01, wlast=wvalid.
REQ-030 Minimum read latency is 3 cycles: accept at T, AR handshake at T+1, R handshake at T+2, cpu_data_ok at T+3; with zero-wait responders a write behaves identically.
REQ-031 A new request is accepted in the same cycle that cpu_data_ok is asserted (back-to-back; the FSM is already in IDLE).

Reset
REQ-032 resetn low SHALL immediately force the FSM to IDLE, all valid/ready outputs to 0, cpu_data_ok=0, cpu_err=0, cpu_rdata=0, and araddr/awaddr/wdata/wstrb=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction without any cpu_data_ok; cpu_addr_ok is available from the first cycle after reset release.

Verification
REQ-034 Write: addr 0x4, data 0x12345678, strb 0xFF, awready=wready=1, bvalid 2 cycles later with bresp=0 -> awvalid/wvalid high one cycle, bready high until the B handshake, cpu_data_ok one pulse, cpu_err=0.
REQ-035 Write with awready delayed 3 cycles, wready=1 -> wvalid high 1 cycle, awvalid high 4 cycles with awaddr=0x4 stable, bready asserted only after the AW handshake.
REQ-036 Read 0x4 with arready delayed 5 cycles, then rdata=0x12345678, rresp=0 -> araddr stable throughout, cpu_rdata=0x12345678, cpu_err=0.
REQ-037 Read with rresp=2'b10 -> cpu_data_ok pulse with cpu_err=1.
REQ-038 resetn driven low while in RD_DATA -> rready=0 immediately, no cpu_data_ok; a subsequent read completes normally.
REQ-039 Write 0x4=0x12345678 immediately followed by read 0x4 (cpu_req held high) -> read accepted in the write's cpu_data_ok cycle, returns 0x12345678.

Source files
------------

// File: rtl/sram_axi_initiator.sv
// ---------------------------------------------------------------------------
// sram_axi_initiator
//
// Bridges a simple SRAM-style CPU request port onto a single-beat AXI master.
// Exactly one transaction is in flight at a time; every transfer is a 64-bit,
// length-1 INCR burst.
//
// Ports
//   clk, resetn                      clock (rising edge), async active-low reset
//   cpu_req/cpu_wr/cpu_addr          CPU request: valid, write flag, byte address
//   cpu_wdata/cpu_wstrb              CPU write data and byte enables
//   cpu_addr_ok                      request accepted this cycle (combinational)
//   cpu_data_ok                      one-cycle completion pulse (registered)
//   cpu_rdata/cpu_err                last read data; error of completed transaction
//   ar*/r*                           AXI read address and read data channels
//   aw*/w*/b*                        AXI write address, write data, write response
// ---------------------------------------------------------------------------
module sram_axi_initiator #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  input  logic [7:0]  cpu_wstrb,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [63:0] cpu_rdata,
  output logic        cpu_err,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,

  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state;
  logic [2:0]  next_state;

  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  // Each write channel keeps its own pending flag so AW and W can complete
  // in either order, or together, and drop valid right after their own beat.
  logic        aw_pend;
  logic        w_pend;

  logic        aw_ok;
  logic        w_ok;
  logic        rd_done;
  logic        wr_done;

  // Single-beat transfers: rlast carries no information, and only bresp[1]
  // (SLVERR/DECERR) is treated as an error.
  logic        unused_ok;
  assign unused_ok = &{1'b0, rlast, bresp[0]};

  assign cpu_addr_ok = cpu_req && (state == IDLE);

  assign aw_ok   = !aw_pend || awready;
  assign w_ok    = !w_pend  || wready;
  assign rd_done = (state == RD_DATA) && rvalid;
  assign wr_done = (state == WR_RESP) && bvalid;

  // Fixed AXI attributes: one 8-byte INCR beat per transaction.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b011;
  assign arburst = 2'b01;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'b011;
  assign awburst = 2'b01;

  // Payloads come straight from the request latches, which only load in
  // IDLE, so they cannot move while any valid is high.
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  // Valid/ready are decoded from flops that reset asynchronously, so they
  // fall to 0 the moment resetn asserts.
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);
  assign awvalid = aw_pend;
  assign wvalid  = w_pend;
  assign wlast   = w_pend;
  assign bready  = (state == WR_RESP);

  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = cpu_wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) next_state = RD_DATA;
      RD_DATA: if (rvalid)  next_state = IDLE;
      WR_REQ:  if (aw_ok && w_ok) next_state = WR_RESP;
      WR_RESP: if (bvalid)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every flop uses non-blocking assignment so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state <= next_state;

      if (cpu_addr_ok) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
      end

      if (cpu_addr_ok && cpu_wr) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (aw_pend && awready) aw_pend <= 1'b0;
        if (w_pend && wready)   w_pend  <= 1'b0;
      end
    end
  end

  // Completion: cpu_data_ok fires the cycle after the R or B handshake, at
  // which point the FSM is already back in IDLE and can accept again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_data_ok <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_data_ok <= rd_done || wr_done;
      if (rd_done) begin
        cpu_rdata <= rdata;
        cpu_err   <= (rresp != 2'b00);
      end else if (wr_done) begin
        cpu_err   <= bresp[1];
      end
    end
  end

endmodule

// File: tb/tb_sram_axi_initiator.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_initiator
//
// Table-driven bench: each record describes one CPU transaction, the slave
// wait states to apply, and the hand-computed outcome (latency from accept
// to cpu_data_ok, valid-high cycle counts, returned data and error flag).
// A small memory model behind the AXI responder makes write-then-read
// sequences observable. A hand-written sequence covers reset mid-read.
// ---------------------------------------------------------------------------
module tb_sram_axi_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [7:0]  cpu_wstrb;
  logic        cpu_addr_ok, cpu_data_ok, cpu_err;
  logic [63:0] cpu_rdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, rready;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_initiator dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    int          gap;        // idle cycles before the request
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          a_dly;      // AR/AW valid cycles before ready
    int          w_dly;      // W valid cycles before ready
    int          r_dly;      // R/B ready cycles before valid
    logic [1:0]  resp;
    int          exp_lat;    // cycles from accept edge to cpu_data_ok
    int          exp_a_cyc;  // arvalid or awvalid high cycles
    int          exp_w_cyc;  // wvalid high cycles
    logic [63:0] exp_rdata;  // cpu_rdata at completion
    bit          exp_err;
  } vec_t;

  int checks = 0;
  int passed = 0;

  logic [63:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  task automatic clear_slave();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = 64'h0BAD_0BAD_0BAD_0BAD; rresp = 2'b11; bresp = 2'b11; rlast = 0;
  endtask

  // Called at a sample point (just after an edge) with the FSM idle. Returns
  // at the sample point where cpu_data_ok is seen, so the next call issues
  // its request in that same cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int lat = -1;
    int a_cnt = 0, w_cnt = 0, r_cnt = 0;
    int bad_addr = 0, bad_order = 0, bad_w = 0;
    bit aw_hs = 0, w_hs = 0, committed = 0;
    logic [31:0] cap_addr = '0;
    logic [63:0] cap_data = '0;
    logic [7:0]  cap_strb = '0;

    repeat (v.gap) step();
    cpu_req = 1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.strb;
    #1 check({tag, "/addr_ok"}, cpu_addr_ok, 1);
    step();
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;

    for (int k = 1; k <= 40; k++) begin
      clear_slave();
      if (k == 1) begin
        check({tag, "/pulse_clear"}, cpu_data_ok, 0);
        cpu_req = 1;
        #1 check({tag, "/busy_no_accept"}, cpu_addr_ok, 0);
        cpu_req = 0;
      end
      if (cpu_data_ok) begin
        lat = k;
        break;
      end
      if (arvalid) begin
        if (araddr !== v.addr) bad_addr++;
        arready = (a_cnt >= v.a_dly);
        a_cnt++;
      end
      if (awvalid) begin
        if (awaddr !== v.addr) bad_addr++;
        awready = (a_cnt >= v.a_dly);
        if (awready) cap_addr = awaddr;
        a_cnt++;
      end
      if (wvalid) begin
        if (!wlast || wdata !== v.wdata || wstrb !== v.strb) bad_w++;
        wready = (w_cnt >= v.w_dly);
        if (wready) begin
          cap_data = wdata;
          cap_strb = wstrb;
        end
        w_cnt++;
      end
      if (rready) begin
        rvalid = (r_cnt >= v.r_dly);
        rresp  = v.resp;
        rlast  = 1;
        if (rvalid) rdata = mem_rd(v.addr);
        r_cnt++;
      end
      if (bready) begin
        if (!(aw_hs && w_hs)) bad_order++;
        if (!committed) begin
          logic [63:0] cur = mem_rd(cap_addr);
          for (int b = 0; b < 8; b++)
            if (cap_strb[b]) cur[b*8 +: 8] = cap_data[b*8 +: 8];
          mem[cap_addr] = cur;
          committed = 1;
        end
        bvalid = (r_cnt >= v.r_dly);
        bresp  = v.resp;
        r_cnt++;
      end
      if (awvalid && awready) aw_hs = 1;
      if (wvalid && wready)   w_hs  = 1;
      step();
    end

    check({tag, "/latency"}, lat, v.exp_lat);
    check({tag, "/a_valid_cycles"}, a_cnt, v.exp_a_cyc);
    check({tag, "/w_valid_cycles"}, w_cnt, v.exp_w_cyc);
    check({tag, "/addr_stable"}, bad_addr, 0);
    check({tag, "/w_payload"}, bad_w, 0);
    check({tag, "/b_after_aw_w"}, bad_order, 0);
    if (lat > 0) begin
      check({tag, "/cpu_rdata"}, cpu_rdata, v.exp_rdata);
      check({tag, "/cpu_err"}, cpu_err, v.exp_err);
    end
  endtask

  vec_t vecs[10];
  vec_t post;

  initial begin
    int ok_seen;

    //          gap wr addr       wdata                  strb   a  w  r  resp   lat a  w  rdata                  err
    vecs[0] = '{2, 1, 32'h4,  64'h12345678,          8'hFF, 0, 0, 2, 2'b00, 5, 1, 1, 64'h0,                 0};
    vecs[1] = '{0, 1, 32'h4,  64'h12345678,          8'hFF, 3, 0, 0, 2'b00, 6, 4, 1, 64'h0,                 0};
    vecs[2] = '{0, 0, 32'h4,  64'h0,                 8'h00, 5, 0, 0, 2'b00, 8, 6, 0, 64'h12345678,          0};
    vecs[3] = '{1, 0, 32'h10, 64'h0,                 8'h00, 0, 0, 0, 2'b10, 3, 1, 0, 64'hDEADBEEF_CAFEF00D, 1};
    vecs[4] = '{0, 1, 32'h8,  64'h11112222_33334444, 8'hF0, 0, 2, 1, 2'b10, 6, 1, 3, 64'hDEADBEEF_CAFEF00D, 1};
    vecs[5] = '{0, 1, 32'h20, 64'hA5,                8'h01, 0, 0, 0, 2'b01, 3, 1, 1, 64'hDEADBEEF_CAFEF00D, 0};
    vecs[6] = '{0, 0, 32'h8,  64'h0,                 8'h00, 0, 0, 0, 2'b01, 3, 1, 0, 64'h11112222_00000000, 1};
    vecs[7] = '{3, 1, 32'h4,  64'h12345678,          8'hFF, 0, 0, 0, 2'b00, 3, 1, 1, 64'h11112222_00000000, 0};
    vecs[8] = '{0, 0, 32'h4,  64'h0,                 8'h00, 0, 0, 0, 2'b00, 3, 1, 0, 64'h12345678,          0};
    vecs[9] = '{0, 0, 32'h20, 64'h0,                 8'h00, 1, 0, 3, 2'b00, 7, 2, 0, 64'hA5,                0};
    post    = '{0, 0, 32'h20, 64'h0,                 8'h00, 0, 0, 0, 2'b00, 3, 1, 0, 64'hA5,                0};

    mem[32'h10] = 64'hDEADBEEF_CAFEF00D;

    resetn = 0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    clear_slave();
    step();
    step();

    check("rst/cpu_data_ok", cpu_data_ok, 0);
    check("rst/cpu_err", cpu_err, 0);
    check("rst/cpu_rdata", cpu_rdata, 0);
    check("rst/cpu_addr_ok", cpu_addr_ok, 0);
    check("rst/valids", {arvalid, awvalid, wvalid, wlast}, 0);
    check("rst/readies", {rready, bready}, 0);
    check("rst/araddr", araddr, 0);
    check("rst/awaddr", awaddr, 0);
    check("rst/wdata", wdata, 0);
    check("rst/wstrb", wstrb, 0);
    check("const/ar_attr", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b011, 2'b01});
    check("const/aw_attr", {awid, awlen, awsize, awburst}, {4'd0, 8'd0, 3'b011, 2'b01});

    resetn = 1;
    step();
    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting in RD_DATA: the read must vanish without a pulse.
    step();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h8;
    #1 check("rstmid/addr_ok", cpu_addr_ok, 1);
    step();
    cpu_req = 0;
    check("rstmid/arvalid", arvalid, 1);
    arready = 1;
    step();
    arready = 0;
    check("rstmid/rready_before", rready, 1);
    resetn = 0;
    #1;
    check("rstmid/rready_after", rready, 0);
    check("rstmid/araddr_cleared", araddr, 0);
    check("rstmid/cpu_rdata_cleared", cpu_rdata, 0);
    ok_seen = 0;
    rvalid = 1; rdata = 64'hFFFF; rresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (cpu_data_ok || rready) ok_seen++;
      step();
    end
    if (cpu_data_ok || rready) ok_seen++;
    rvalid = 0;
    resetn = 1;
    check("rstmid/no_pulse_or_ready", ok_seen, 0);
    run_txn(post, "post_rst");
    step();
    check("post_rst/pulse_ends", cpu_data_ok, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
